// File: rtl/ps2_key_source_pkg.sv
// ---------------------------------------------------------------------------
// | ps2_pkg : shared states, PS/2 byte codes and status-byte helper          |
// | Revision: 1.0                                                            |
// ---------------------------------------------------------------------------
`default_nettype none

package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam logic [7:0] PS2_BAT    = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_OVR_LO = 8'h00;
  localparam logic [7:0] PS2_OVR_HI = 8'hFF;

  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  // Keyboard housekeeping replies that never map to a key
  function automatic logic is_status_byte(input logic [7:0] b);
    return (b == PS2_BAT) || (b == PS2_ACK) || (b == PS2_RESEND) ||
           (b == PS2_ECHO) || (b == PS2_OVR_LO) || (b == PS2_OVR_HI);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_key_source_if.sv
// ---------------------------------------------------------------------------
// | ps2_key_source_if : PS/2 pin inputs and key-event outputs                |
// | Revision: 1.0                                                            |
// ---------------------------------------------------------------------------
`default_nettype none

interface ps2_key_source_if;
  logic        ps2_clk_in;
  logic        ps2_data_in;
  logic [10:0] ps2_key;
  logic        frame_err;

  modport master (
    output ps2_clk_in,
    output ps2_data_in,
    input  ps2_key,
    input  frame_err
  );

  modport slave (
    input  ps2_clk_in,
    input  ps2_data_in,
    output ps2_key,
    output frame_err
  );
endinterface

`default_nettype wire

// File: rtl/ps2_key_source_line_filter.sv
// ---------------------------------------------------------------------------
// | ps2_line_filter : 2-FF sync, PS/2 clock glitch filter, falling strobe    |
// | Revision: 1.0                                                            |
// ---------------------------------------------------------------------------
`default_nettype none

module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic fall_stb_o,
  output logic data_s_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    clk_sync_q;
  logic [1:0]    data_sync_q;
  logic          filt_q;
  logic [CW-1:0] filt_cnt_q;
  logic          flip_d;

  // The filtered level flips on the FILTER_LEN-th consecutive differing sample
  assign flip_d     = (clk_sync_q[1] != filt_q) && (filt_cnt_q == CW'(FILTER_LEN - 1));
  assign fall_stb_o = flip_d && filt_q;
  assign data_s_o   = data_sync_q[1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_q      <= 1'b1;
      filt_cnt_q  <= '0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      if (clk_sync_q[1] == filt_q) begin
        filt_cnt_q <= '0;
      end else if (flip_d) begin
        filt_q     <= clk_sync_q[1];
        filt_cnt_q <= '0;
      end else begin
        filt_cnt_q <= filt_cnt_q + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ps2_key_source.sv
// ---------------------------------------------------------------------------
// | ps2_key_source : PS/2 frame receiver producing the 11-bit ps2_key word   |
// | Revision: 1.0                                                            |
// ---------------------------------------------------------------------------
`default_nettype none

module ps2_key_source
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 9984
) (
  input  logic             Clk,
  input  logic             I_RESET,
  ps2_key_source_if.slave  bus
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic          fall_stb;
  logic          data_s;

  ps2_state_e    state_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          parity_q;
  logic          byte_vld_q;
  logic          ext_q;
  logic          brk_q;
  logic [2:0]    skip_q;
  logic [TW-1:0] to_cnt_q;
  logic [10:0]   key_q;
  logic          frame_err_q;

  ps2_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clk_i      (Clk),
    .rst_i      (I_RESET),
    .ps2_clk_i  (bus.ps2_clk_in),
    .ps2_data_i (bus.ps2_data_in),
    .fall_stb_o (fall_stb),
    .data_s_o   (data_s)
  );

  assign bus.ps2_key   = key_q;
  assign bus.frame_err = frame_err_q;

  always_ff @(posedge Clk) begin
    if (I_RESET) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      byte_vld_q  <= 1'b0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      skip_q      <= '0;
      to_cnt_q    <= '0;
      key_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      byte_vld_q  <= 1'b0;

      // Byte captured on the previous STOP strobe is interpreted here
      if (byte_vld_q) begin
        if (skip_q != 3'd0) begin
          skip_q <= skip_q - 1'b1;
        end else if (shift_q == PS2_PAUSE) begin
          skip_q <= PAUSE_SKIP;
        end else if (shift_q == PS2_EXT) begin
          ext_q <= 1'b1;
        end else if (shift_q == PS2_BRK) begin
          brk_q <= 1'b1;
        end else if (!ext_q && !brk_q && is_status_byte(shift_q)) begin
          key_q <= key_q;
        end else begin
          key_q <= {~key_q[10], ~brk_q, ext_q, shift_q};
          ext_q <= 1'b0;
          brk_q <= 1'b0;
        end
      end

      if (state_q == IDLE || fall_stb) begin
        to_cnt_q <= '0;
      end else begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (fall_stb && !data_s) begin
            state_q   <= DATA;
            bit_cnt_q <= '0;
          end
        end
        DATA: begin
          if (fall_stb) begin
            shift_q   <= {data_s, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) begin
              state_q <= PARITY;
            end
          end
        end
        PARITY: begin
          if (fall_stb) begin
            parity_q <= data_s;
            state_q  <= STOP;
          end
        end
        STOP: begin
          if (fall_stb) begin
            state_q <= IDLE;
            if (data_s && ((^shift_q) ^ parity_q)) begin
              byte_vld_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
              ext_q       <= 1'b0;
              brk_q       <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase

      // Stalled keyboard: abandon the partial frame and any pending prefix
      if (state_q != IDLE && !fall_stb && to_cnt_q == TW'(TIMEOUT - 1)) begin
        state_q     <= IDLE;
        frame_err_q <= 1'b1;
        ext_q       <= 1'b0;
        brk_q       <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ps2_key_source.sv
// ---------------------------------------------------------------------------
// | tb_ps2_key_source : directed + random frames against a key-event model   |
// | Revision: 1.0                                                            |
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_ps2_key_source;

  localparam int TIMEOUT = 9984;
  localparam int HALF    = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ps2_key_source_if bus ();

  ps2_key_source #(
    .FILTER_LEN (8),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .Clk     (clk),
    .I_RESET (rst),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [10:0] m_key  = '0;
  bit          m_ext  = 1'b0;
  bit          m_brk  = 1'b0;
  int          m_skip = 0;
  int          exp_err = 0;

  int err_pulses = 0;
  int err_hi     = 0;
  bit prev_err   = 1'b0;

  always @(negedge clk) begin
    if (bus.frame_err === 1'b1) err_hi++;
    if (bus.frame_err === 1'b1 && !prev_err) err_pulses++;
    prev_err = (bus.frame_err === 1'b1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_key = '0; m_ext = 0; m_brk = 0; m_skip = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (m_skip > 0) m_skip--;
    else if (b == 8'hE1) m_skip = 7;
    else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (!m_ext && !m_brk && (b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF})) begin
    end else begin
      m_key = {~m_key[10], ~m_brk, m_ext, b};
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  task automatic send_bit(input logic b);
    bus.ps2_data_in = b;
    repeat (HALF) @(negedge clk);
    bus.ps2_clk_in = 1'b0;
    repeat (HALF) @(negedge clk);
    bus.ps2_clk_in = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(~bad_stop);
    if (bad_par || bad_stop) begin
      m_ext = 0; m_brk = 0; exp_err++;
    end else begin
      model_byte(b);
    end
    repeat (4) @(negedge clk);
    bus.ps2_data_in = 1'b1;
  endtask

  task automatic frame_chk(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    send_frame(b, bad_par, bad_stop);
    chk($sformatf("key_after_%02h", b), 32'(bus.ps2_key), 32'(m_key));
    chk($sformatf("errcnt_after_%02h", b), err_pulses, exp_err);
  endtask

  logic [7:0] pool [7] = '{8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'hFA, 8'h00, 8'hFF};
  logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

  initial begin
    logic [7:0] rb;
    int r;
    bus.ps2_clk_in  = 1'b1;
    bus.ps2_data_in = 1'b1;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_key", 32'(bus.ps2_key), 32'h0);
    chk("reset_err", 32'(bus.frame_err), 32'h0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Space press / release
    frame_chk(8'h29, 0, 0);
    chk("space_press", 32'(bus.ps2_key), 32'h629);
    frame_chk(8'hF0, 0, 0);
    chk("brk_prefix_hold", 32'(bus.ps2_key), 32'h629);
    frame_chk(8'h29, 0, 0);
    chk("space_release", 32'(bus.ps2_key), 32'h029);

    // Extended press / release
    frame_chk(8'hE0, 0, 0);
    frame_chk(8'h75, 0, 0);
    chk("ext_press", 32'(bus.ps2_key), 32'h775);
    frame_chk(8'hE0, 0, 0);
    frame_chk(8'hF0, 0, 0);
    frame_chk(8'h75, 0, 0);
    chk("ext_release", 32'(bus.ps2_key), 32'h175);

    // Parity error then clean retry
    frame_chk(8'h1C, 1, 0);
    chk("par_err_key", 32'(bus.ps2_key), 32'h175);
    frame_chk(8'h1C, 0, 0);
    chk("retry_1c", 32'(bus.ps2_key), 32'h61C);

    // Stalled frame: start + 5 data bits, clock left high
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
    repeat (TIMEOUT - HALF - 5) @(negedge clk);
    chk("timeout_not_early", err_pulses, exp_err);
    repeat (45) @(negedge clk);
    exp_err++;
    m_ext = 0; m_brk = 0;
    chk("timeout_err", err_pulses, exp_err);
    frame_chk(8'h21, 0, 0);
    chk("after_timeout", 32'(bus.ps2_key), 32'h221);

    // Pause sequence is swallowed whole
    for (int i = 0; i < 8; i++) frame_chk(pause_seq[i], 0, 0);
    chk("pause_no_event", 32'(bus.ps2_key), 32'h221);
    frame_chk(8'h16, 0, 0);
    chk("after_pause", 32'(bus.ps2_key), 32'h616);

    // Random traffic with prefixes, status bytes and occasional corruption
    for (int n = 0; n < 24; n++) begin
      r = int'($urandom_range(0, 11));
      rb = (r < 7) ? pool[r] : 8'($urandom);
      r = int'($urandom_range(0, 7));
      frame_chk(rb, r == 0, r == 1);
    end

    // Reset in the middle of a frame
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("midreset_key", 32'(bus.ps2_key), 32'h0);
    chk("midreset_err", 32'(bus.frame_err), 32'h0);
    repeat (30) @(negedge clk);
    chk("midreset_no_err", err_pulses, exp_err);
    frame_chk(8'h05, 0, 0);
    chk("after_reset", 32'(bus.ps2_key), 32'h605);

    chk("err_pulse_width", err_hi, exp_err);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ps2_key_source.md
Name: ps2_key_source

Overview:
- Receives raw PS/2 keyboard clock/data lines and produces the 11-bit ps2_key event word consumed by the core's keyboard decode: [10] toggle, [9] pressed, [8] extended, [7:0] scancode.
- Intended for standalone and simulation builds where no HPS is present.
- Sits between the keyboard pins and the key-to-button mapping logic.
- Handles frame reception, parity/stop checking, E0/F0 prefixes, E1 Pause suppression and a stall timeout.

Parameters:
- FILTER_LEN, 8: consecutive identical synchronised samples needed before the filtered PS/2 clock changes level.
- TIMEOUT, 9984: Clk cycles without a falling clock edge, mid-frame, before the receiver aborts (1 ms at 9.984 MHz).

Ports:
- Clk, input, 1: system clock; all logic on its rising edge.
- I_RESET, input, 1: synchronous, active-high reset.
- ps2_clk_in, input, 1: raw PS/2 clock, asynchronous.
- ps2_data_in, input, 1: raw PS/2 data, asynchronous.
- ps2_key, output, 11: event word; [10] toggles on each new event.
- frame_err, output, 1: one-cycle pulse on a parity, stop-bit or timeout error.

Behaviour:
- Reset: ps2_key=0, frame_err=0, state IDLE, bit counter 0, ext/brk flags 0, E1 skip counter 0, timeout counter 0, filtered clock=1. I_RESET dominates every other event in the same cycle.
- Input conditioning: 2-FF synchroniser on both lines. Filtered clock flips only after FILTER_LEN equal samples. The falling-edge strobe fires in the cycle the filtered clock goes 1->0, and data is sampled from the synchronised data line in that same cycle.
- Receive FSM, advancing on falling-edge strobes only:
  - IDLE: data=0 -> DATA, bit count 0. Data=1 -> stay IDLE, no error.
  - DATA: shift the bit in LSB-first; after 8 bits -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: -> IDLE. If stop=1 and the XOR of the 8 data bits plus parity is 1 (odd parity), the byte is valid. Otherwise pulse frame_err and clear ext/brk.
- Timeout: in any state other than IDLE, the counter increments each cycle and clears on every strobe. On reaching TIMEOUT: -> IDLE, pulse frame_err, clear ext/brk. The counter is held at 0 in IDLE.
- Byte handling, on the cycle after the STOP strobe (so ps2_key updates 1 cycle after the stop-bit falling edge):
  - Skip counter nonzero: decrement it, no event.
  - 0xE1: load skip=7, no event (suppresses the Pause sequence).
  - 0xE0: set ext, no event.
  - 0xF0: set brk, no event.
  - 0xAA, 0xFA, 0xFE, 0xEE, 0x00, 0xFF with ext=0 and brk=0: discarded (BAT/ack/resend/echo/overrun).
  - Any other byte: ps2_key <= {~ps2_key[10], ~brk, ext, byte}; then clear ext and brk.
- ps2_key holds its value between events. The toggle bit is the only event indicator; downstream compares [10] against its stored copy.
- Prefix flags persist across bytes until consumed or cleared by an error or reset.
- Back-to-back frames must decode with zero idle cycles between the STOP and next start strobes beyond filter latency.
- Reset mid-frame: partial byte discarded, no frame_err; the next clean frame decodes normally.

Decomposition:
- Shared package ps2_pkg:
  - state enum {IDLE, DATA, PARITY, STOP};
  - byte constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_PAUSE=8'hE1, PS2_BAT=8'hAA, PS2_ACK=8'hFA;
  - PAUSE_SKIP=7.
- One sub-module, ps2_line_filter: synchroniser, FILTER_LEN glitch filter and falling-edge strobe. Outputs fall_stb and data_s.
- Framing, prefix handling and event output live in ps2_key_source.

Test Plan:
- Frame 0x29 (Space), correct parity -> ps2_key=11'h629, frame_err never asserted.
- Then F0 29 -> ps2_key=11'h029; no change after the F0 byte alone.
- E0 75 press from the toggle=0 state -> ps2_key=11'h775; E0 F0 75 then gives 11'h175.
- Frame 0x1C with the parity bit inverted -> one-cycle frame_err, ps2_key unchanged. Following good 0x1C -> toggle flips, [9]=1, [7:0]=8'h1C.
- Start plus 5 data bits then the clock held high for TIMEOUT+10 cycles -> frame_err pulse at TIMEOUT, FSM in IDLE. Next full frame 0x21 decodes correctly.
- Full Pause sequence E1 14 77 E1 F0 14 F0 77 -> no ps2_key change. Then 0x16 -> event emitted.
- Assert I_RESET for 1 cycle after the 4th data bit -> all outputs 0. Subsequent 0x05 -> ps2_key=11'h605.
